exe_stage: RTL

//  EXE pipeline stage of the LoongArch single-issue 5-stage core. Sits between ID and MEM.
//  - Latches the ID bundle and selects the ALU operands.
//  - Instantiates alu and issues the data-SRAM request.
//  - Passes result and write-back info to MEM under valid/allowin handshake.
//  - Exports a forwarding/hazard view of its in-flight instruction back to ID.

---
 rtl/exe_stage_pkg.sv | 46 ++++
 rtl/exe_stage_alu.sv | 48 ++++
 rtl/exe_stage.sv | 96 +++++++++
 3 files changed

// File: rtl/exe_stage_pkg.sv
// Shared widths, ALU opcode bit positions and bus layouts for the EXE stage.
// Used by exe_stage and its ALU; see exe_stage.sv for the EXE_FWD_EN option.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 150;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int ES_FWD_BUS_WD   = 39;  // {valid, dest[4:0], result[31:0], is_load}
  localparam int ALU_OP_WD       = 12;

  // One-hot alu_op bit positions
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;

  typedef struct packed {
    logic [ALU_OP_WD-1:0] alu_op;
    logic                 res_from_mem;
    logic                 src1_is_pc;
    logic                 src2_is_imm;
    logic                 gr_we;
    logic                 mem_we;
    logic [4:0]           dest;
    logic [31:0]          imm;
    logic [31:0]          rj_value;
    logic [31:0]          rkd_value;
    logic [31:0]          pc;
  } ds_to_es_t;

  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

endpackage

// File: rtl/exe_stage_alu.sv
// Single-cycle 32-bit ALU with a one-hot operation select.
// SUB, SLT and SLTU share the adder; LUI passes the pre-shifted immediate through.
module exe_stage_alu
  import exe_stage_pkg::*;
(
  input  logic [ALU_OP_WD-1:0] alu_op,
  input  logic [31:0]          alu_src1,
  input  logic [31:0]          alu_src2,
  output logic [31:0]          alu_result
);

  logic        use_sub;
  logic [31:0] adder_b;
  logic [32:0] adder_sum;
  logic        slt_res;
  logic        sltu_res;
  logic [4:0]  shamt;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;

  assign use_sub   = alu_op[OP_SUB] | alu_op[OP_SLT] | alu_op[OP_SLTU];
  assign adder_b   = use_sub ? ~alu_src2 : alu_src2;
  assign adder_sum = {1'b0, alu_src1} + {1'b0, adder_b} + {32'b0, use_sub};

  // Signed less-than: differing signs decide directly, otherwise the difference sign does.
  assign slt_res  = (alu_src1[31] & ~alu_src2[31])
                  | (~(alu_src1[31] ^ alu_src2[31]) & adder_sum[31]);
  assign sltu_res = ~adder_sum[32];

  assign shamt   = alu_src2[4:0];
  assign sll_res = alu_src1 << shamt;
  assign srl_res = alu_src1 >> shamt;
  assign sra_res = $signed(alu_src1) >>> shamt;

  assign alu_result = ({32{alu_op[OP_ADD] | alu_op[OP_SUB]}} & adder_sum[31:0])
                    | ({32{alu_op[OP_SLT]}}  & {31'b0, slt_res})
                    | ({32{alu_op[OP_SLTU]}} & {31'b0, sltu_res})
                    | ({32{alu_op[OP_AND]}}  & (alu_src1 & alu_src2))
                    | ({32{alu_op[OP_NOR]}}  & ~(alu_src1 | alu_src2))
                    | ({32{alu_op[OP_OR]}}   & (alu_src1 | alu_src2))
                    | ({32{alu_op[OP_XOR]}}  & (alu_src1 ^ alu_src2))
                    | ({32{alu_op[OP_SLL]}}  & sll_res)
                    | ({32{alu_op[OP_SRL]}}  & srl_res)
                    | ({32{alu_op[OP_SRA]}}  & sra_res)
                    | ({32{alu_op[OP_LUI]}}  & alu_src2);

endmodule

// File: rtl/exe_stage.sv
// EXE stage of the 5-stage LoongArch core: latches the ID bundle, runs the ALU,
// issues data-SRAM requests and exports a hazard view to ID. Option: EXE_FWD_EN.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  output logic                       es_fwd_valid,
  output logic [4:0]                 es_fwd_dest,
  output logic [31:0]                es_fwd_result,
  output logic                       es_fwd_is_load
);

  logic      es_valid_q, es_valid_d;
  ds_to_es_t es_bus_q,   es_bus_d;
  logic      es_ready_go;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;
  es_to_ms_t   ms_bus;

  assign es_ready_go = 1'b1;
  assign es_allowin  = ~es_valid_q | (es_ready_go & ms_allowin);

  // NOTE: next-state logic assigns every target up front (hold) so no latch is inferred.
  always_comb begin
    es_valid_d = es_valid_q;
    es_bus_d   = es_bus_q;
    if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
      if (ds_to_es_valid) begin
        es_bus_d = ds_to_es_t'(ds_to_es_bus);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
    end else begin
      es_valid_q <= es_valid_d;
    end
  end

  // NOTE: the bundle register is left unreset; every consumer is qualified by es_valid_q.
  always_ff @(posedge clk) begin
    es_bus_q <= es_bus_d;
  end

  assign alu_src1 = es_bus_q.src1_is_pc  ? es_bus_q.pc  : es_bus_q.rj_value;
  assign alu_src2 = es_bus_q.src2_is_imm ? es_bus_q.imm : es_bus_q.rkd_value;

  exe_stage_alu u_alu (
    .alu_op     (es_bus_q.alu_op),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_result (alu_result)
  );

  assign es_to_ms_valid      = es_valid_q & es_ready_go;
  assign ms_bus.res_from_mem = es_bus_q.res_from_mem;
  assign ms_bus.gr_we        = es_bus_q.gr_we;
  assign ms_bus.dest         = es_bus_q.dest;
  assign ms_bus.alu_result   = alu_result;
  assign ms_bus.pc           = es_bus_q.pc;
  assign es_to_ms_bus        = ms_bus;

  // Requests re-issue every stalled cycle; harmless because only word ld/st exist.
  assign data_sram_en    = es_valid_q & (es_bus_q.res_from_mem | es_bus_q.mem_we);
  assign data_sram_we    = {4{es_valid_q & es_bus_q.mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_bus_q.rkd_value;

  assign es_fwd_valid = es_valid_q & es_bus_q.gr_we & (es_bus_q.dest != 5'd0);
  assign es_fwd_dest  = es_bus_q.dest;

`ifdef EXE_FWD_EN
  assign es_fwd_result  = alu_result;
  assign es_fwd_is_load = es_bus_q.res_from_mem;
`else
  // Without bypassing every EXE RAW hazard looks like a load to ID and stalls it.
  assign es_fwd_result  = 32'b0;
  assign es_fwd_is_load = es_fwd_valid;
`endif

endmodule
